// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding and the result-checker FSM states.
// Also used by the ALU datapath and the ALU control decoder.
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_NOR  = 3'b101;
    localparam logic [2:0] OP_SLT  = 3'b110;
    localparam logic [2:0] OP_SLTU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10,
        ST_DONE  = 2'b11
    } chk_state_e;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden ALU: the result and zero flag the CPU ALU must produce.
module alu_ref_model
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       s,
    output logic [WIDTH-1:0] expected,
    output logic             expected_zero
);

    always_comb begin
        // NOTE: the default ahead of the case keeps this block free of inferred latches.
        expected = '0;
        case (s)
            OP_ADD:  expected = a + b;
            OP_SUB:  expected = a - b;
            OP_AND:  expected = a & b;
            OP_OR:   expected = a | b;
            OP_XOR:  expected = a ^ b;
            OP_NOR:  expected = ~(a | b);
            OP_SLT:  expected = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: expected = {{(WIDTH-1){1'b0}}, (a < b)};
            default: expected = '0;
        endcase
    end

    assign expected_zero = (expected == '0);

endmodule

// File: rtl/alu_result_checker.sv
// Response-side ALU checker: accepts NUM_VECTORS vectors per run, compares each
// against the golden model one cycle later, counts mismatches, keeps the first one.
module alu_result_checker
    import alu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int NUM_VECTORS = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       s,
    input  logic [WIDTH-1:0] result,
    input  logic             zero,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] chk_count,
    output logic [CNT_W-1:0] err_count,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic [2:0]       fail_s,
    output logic [WIDTH-1:0] fail_result
);

    localparam int ACC_W = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
    localparam logic [ACC_W-1:0] LAST_IDX = ACC_W'(NUM_VECTORS - 1);

    chk_state_e       state;
    logic [ACC_W-1:0] acc_cnt;

    logic             accept;
    logic [WIDTH-1:0] ref_expected;
    logic             ref_expected_zero;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [2:0]       s1_s;
    logic [WIDTH-1:0] s1_result;
    logic             s1_zero;
    logic [WIDTH-1:0] s1_expected;
    logic             s1_expected_zero;
    logic             s1_mismatch;

    assign accept = in_valid & in_ready;

    alu_ref_model #(.WIDTH(WIDTH)) u_ref (
        .a             (a),
        .b             (b),
        .s             (s),
        .expected      (ref_expected),
        .expected_zero (ref_expected_zero)
    );

    // NOTE: stage-1 payload carries no reset; s1_valid alone decides whether it is used.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_a             <= a;
            s1_b             <= b;
            s1_s             <= s;
            s1_result        <= result;
            s1_zero          <= zero;
            s1_expected      <= ref_expected;
            s1_expected_zero <= ref_expected_zero;
        end
    end

    assign s1_mismatch = (s1_result != s1_expected) | (s1_zero != s1_expected_zero);

    // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            acc_cnt     <= '0;
            in_ready    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            s1_valid    <= 1'b0;
            chk_count   <= '0;
            err_count   <= '0;
            fail_a      <= '0;
            fail_b      <= '0;
            fail_s      <= '0;
            fail_result <= '0;
        end else begin
            s1_valid <= accept;

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        acc_cnt     <= '0;
                        chk_count   <= '0;
                        err_count   <= '0;
                        fail_a      <= '0;
                        fail_b      <= '0;
                        fail_s      <= '0;
                        fail_result <= '0;
                        if (NUM_VECTORS == 0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= ST_RUN;
                            in_ready <= 1'b1;
                            busy     <= 1'b1;
                            done     <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        acc_cnt <= acc_cnt + 1'b1;
                        if (acc_cnt == LAST_IDX) begin
                            state    <= ST_DRAIN;
                            in_ready <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    state <= ST_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase

            // Stage 2: the pipeline is empty whenever start can be taken, so this never races the clear.
            if (s1_valid) begin
                if (chk_count != '1) begin
                    chk_count <= chk_count + 1'b1;
                end
                if (s1_mismatch) begin
                    if (err_count == '0) begin
                        fail_a      <= s1_a;
                        fail_b      <= s1_b;
                        fail_s      <= s1_s;
                        fail_result <= s1_result;
                    end
                    if (err_count != '1) begin
                        err_count <= err_count + 1'b1;
                    end
                end
            end
        end
    end

    assign pass = done & (err_count == '0);

endmodule
